// File: rtl/ctrl_mc_if.sv
// Control bundle between the SISC multi-cycle controller and its datapath.
// The controller uses the master view. The datapath or testbench uses the slave view.
interface ctrl_mc_if #(
    parameter int CNTW = 16
);
    // Instruction fields and status coming from the datapath
    logic [3:0]      opcode;
    logic [3:0]      mm;
    logic [3:0]      stat;
    logic            mem_ack;

    // Datapath controls driven by the controller
    logic            pc_rst;
    logic            pc_write;
    logic            pc_sel;
    logic            br_sel;
    logic            ir_load;
    logic            rf_we;
    logic            wb_sel;
    logic            wa_sel;
    logic [1:0]      alu_op;
    logic            mem_req;
    logic            dm_we;
    logic            halted;
    logic            fault;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  opcode, mm, stat, mem_ack,
        output pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, wa_sel,
               alu_op, mem_req, dm_we, halted, fault, instr_count
    );

    modport slave (
        output opcode, mm, stat, mem_ack,
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, wb_sel, wa_sel,
               alu_op, mem_req, dm_we, halted, fault, instr_count
    );
endinterface

// File: rtl/ctrl_mc.sv
// Multi-cycle control FSM for the SISC datapath.
// It sequences fetch, decode, execute, memory and writeback.
// It waits on a memory handshake with a timeout, resolves conditional branches from the status flags, and performs a two-cycle SWP writeback.
// HLT and faults park the machine in HALT until reset.
module ctrl_mc #(
    parameter int         TIMEOUT = 8,
    parameter int         CNTW    = 16,
    parameter logic [3:0] AM_IMM  = 4'd8
) (
    input  logic      clk,
    input  logic      rst,
    ctrl_mc_if.master bus
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_WB_SWP, S_HALT
    } state_t;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_LOD  = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd2;
    localparam logic [3:0] OP_SWP  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_ALU  = 4'd8;
    localparam logic [3:0] OP_HLT  = 4'd15;

    // The wait counter only has to reach TIMEOUT-1.
    localparam int            WW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LIMIT = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          state;
    state_t          next_state;
    logic [WW-1:0]   wait_cnt;
    logic [CNTW-1:0] count;
    logic            fault_q;

    logic            is_mem;
    logic            is_illegal;
    logic            is_imm;
    logic            taken;
    logic            timeout_hit;
    logic            retire;

    assign is_mem      = (bus.opcode == OP_LOD) || (bus.opcode == OP_STR);
    assign is_illegal  = (bus.opcode > OP_ALU) && (bus.opcode < OP_HLT);
    assign is_imm      = (bus.mm == AM_IMM);
    assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == WAIT_LIMIT) && !bus.mem_ack;
    assign retire      = (next_state == S_FETCH) &&
                         ((state == S_WRITEBACK) || (state == S_WB_SWP));

    // Resolve the branch condition from the flags present during EXECUTE
    always_comb begin
        taken = 1'b0;
        case (bus.opcode)
            OP_BRA, OP_BRR: taken = (bus.mm == 4'd0) || ((bus.mm & bus.stat) != 4'd0);
            OP_BNE, OP_BNR: taken = ((bus.mm & bus.stat) == 4'd0);
            default:        taken = 1'b0;
        endcase
    end

    // State register; reset can arrive in any state, including mid-MEM
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_RESET;
        else     state <= next_state;
    end

    // Next-state logic
    // NOTE: assign a default first in every combinational block so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            S_RESET:     next_state = S_FETCH;
            S_FETCH:     next_state = S_DECODE;
            S_DECODE:    next_state = (bus.opcode == OP_HLT || is_illegal) ? S_HALT : S_EXECUTE;
            S_EXECUTE:   next_state = S_MEM;
            S_MEM: begin
                if (!is_mem || bus.mem_ack) next_state = S_WRITEBACK;
                else if (timeout_hit)       next_state = S_HALT;
                else                        next_state = S_MEM;
            end
            S_WRITEBACK: next_state = (bus.opcode == OP_SWP) ? S_WB_SWP : S_FETCH;
            S_WB_SWP:    next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_RESET;
        endcase
    end

    // Datapath controls, decoded from the present state and the instruction fields
    always_comb begin
        bus.pc_rst   = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.ir_load  = 1'b0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.wa_sel   = 1'b0;
        bus.alu_op   = 2'b00;
        bus.mem_req  = 1'b0;
        bus.dm_we    = 1'b0;
        bus.halted   = 1'b0;
        case (state)
            S_RESET: bus.pc_rst = 1'b1;
            S_FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
            end
            S_EXECUTE: begin
                if (bus.opcode == OP_ALU) bus.alu_op = {1'b0, is_imm};
                if (is_mem)               bus.alu_op = {1'b1, is_imm};
                if (taken) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = 1'b1;
                    bus.br_sel   = (bus.opcode == OP_BRR) || (bus.opcode == OP_BNR);
                end
            end
            S_MEM: begin
                if (is_mem) begin
                    bus.mem_req = 1'b1;
                    bus.alu_op  = {1'b1, is_imm};
                    bus.dm_we   = (bus.opcode == OP_STR);
                end
            end
            S_WRITEBACK: begin
                bus.rf_we  = (bus.opcode == OP_ALU) || (bus.opcode == OP_LOD) ||
                             (bus.opcode == OP_SWP);
                bus.wb_sel = (bus.opcode == OP_LOD);
            end
            S_WB_SWP: begin
                bus.rf_we  = 1'b1;
                bus.wa_sel = 1'b1;
            end
            S_HALT:  bus.halted = 1'b1;
            default: bus.pc_rst = 1'b0;
        endcase
    end

    // Memory wait counter: held at zero outside MEM, counts cycles without an ack inside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (state != S_MEM)  wait_cnt <= '0;
        else if (!bus.mem_ack)    wait_cnt <= wait_cnt + WW'(1);
    end

    // Sticky fault: set by an illegal opcode or a memory timeout, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fault_q <= 1'b0;
        else if ((state == S_DECODE && is_illegal) ||
                 (state == S_MEM && is_mem && timeout_hit))
            fault_q <= 1'b1;
    end

    // Retired-instruction counter; it saturates instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         count <= '0;
        else if (retire && (count != '1)) count <= count + CNTW'(1);
    end

    assign bus.fault       = fault_q;
    assign bus.instr_count = count;

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc.
// A cycle-by-cycle vector table runs a program of ALU, LOD, STR, branch, SWP and HLT.
// Hand-written sequences then cover the memory timeout, an asynchronous reset in the middle of MEM, and an illegal opcode.
module tb_ctrl_mc;

    localparam logic [13:0] PC_RST = 14'h2000;
    localparam logic [13:0] PC_WR  = 14'h1000;
    localparam logic [13:0] PC_SEL = 14'h0800;
    localparam logic [13:0] BR_SEL = 14'h0400;
    localparam logic [13:0] IR_LD  = 14'h0200;
    localparam logic [13:0] RF_WE  = 14'h0100;
    localparam logic [13:0] WB_SEL = 14'h0080;
    localparam logic [13:0] WA_SEL = 14'h0040;
    localparam logic [13:0] ALU_A  = 14'h0020;
    localparam logic [13:0] ALU_I  = 14'h0010;
    localparam logic [13:0] MREQ   = 14'h0008;
    localparam logic [13:0] DMWE   = 14'h0004;
    localparam logic [13:0] HALTED = 14'h0002;
    localparam logic [13:0] FAULT  = 14'h0001;
    localparam logic [13:0] FETCH  = IR_LD | PC_WR;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [3:0]  st;
        logic        ack;
        logic [13:0] ctl;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    vec_t vecs[$];

    ctrl_mc_if #(.CNTW(16)) bus ();

    ctrl_mc #(.TIMEOUT(8), .CNTW(16), .AM_IMM(4'd8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] ctl_now();
        return {bus.pc_rst, bus.pc_write, bus.pc_sel, bus.br_sel, bus.ir_load,
                bus.rf_we, bus.wb_sel, bus.wa_sel, bus.alu_op,
                bus.mem_req, bus.dm_we, bus.halted, bus.fault};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             passed++;
    endtask

    task automatic add(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] st,
                       input logic ack, input logic [13:0] ctl, input logic [15:0] cnt);
        vec_t v;
        v.op = op; v.mm = mm; v.st = st; v.ack = ack; v.ctl = ctl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] mm,
                         input logic [3:0] st, input logic ack);
        bus.opcode  = op;
        bus.mm      = mm;
        bus.stat    = st;
        bus.mem_ack = ack;
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, release it, and leave the FSM in RESET
    task automatic apply_reset();
        rst = 1'b1;
        drive(4'd0, 4'd0, 4'd0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n;

        // Program: each entry is one cycle, giving the inputs and the expected controls and instr_count
        add(4'd0, 4'd0, 4'd0, 1'b0, PC_RST, 16'd0);                   // RESET
        add(4'd8, 4'd0, 4'd0, 1'b0, FETCH, 16'd0);                    // ALU reg
        add(4'd8, 4'd0, 4'd0, 1'b0, 14'h0, 16'd0);
        add(4'd8, 4'd0, 4'd0, 1'b0, 14'h0, 16'd0);
        add(4'd8, 4'd0, 4'd0, 1'b0, 14'h0, 16'd0);
        add(4'd8, 4'd0, 4'd0, 1'b0, RF_WE, 16'd0);
        add(4'd8, 4'd8, 4'd0, 1'b0, FETCH, 16'd1);                    // ALU imm
        add(4'd8, 4'd8, 4'd0, 1'b0, 14'h0, 16'd1);
        add(4'd8, 4'd8, 4'd0, 1'b0, ALU_I, 16'd1);
        add(4'd8, 4'd8, 4'd0, 1'b1, 14'h0, 16'd1);
        add(4'd8, 4'd8, 4'd0, 1'b0, RF_WE, 16'd1);
        add(4'd1, 4'd8, 4'd0, 1'b0, FETCH, 16'd2);                    // LOD imm, 3 waits
        add(4'd1, 4'd8, 4'd0, 1'b0, 14'h0, 16'd2);
        add(4'd1, 4'd8, 4'd0, 1'b0, ALU_A | ALU_I, 16'd2);
        add(4'd1, 4'd8, 4'd0, 1'b0, MREQ | ALU_A | ALU_I, 16'd2);
        add(4'd1, 4'd8, 4'd0, 1'b0, MREQ | ALU_A | ALU_I, 16'd2);
        add(4'd1, 4'd8, 4'd0, 1'b0, MREQ | ALU_A | ALU_I, 16'd2);
        add(4'd1, 4'd8, 4'd0, 1'b1, MREQ | ALU_A | ALU_I, 16'd2);
        add(4'd1, 4'd8, 4'd0, 1'b0, RF_WE | WB_SEL, 16'd2);
        add(4'd2, 4'd0, 4'd0, 1'b0, FETCH, 16'd3);                    // STR, immediate ack
        add(4'd2, 4'd0, 4'd0, 1'b0, 14'h0, 16'd3);
        add(4'd2, 4'd0, 4'd0, 1'b0, ALU_A, 16'd3);
        add(4'd2, 4'd0, 4'd0, 1'b1, MREQ | DMWE | ALU_A, 16'd3);
        add(4'd2, 4'd0, 4'd0, 1'b0, 14'h0, 16'd3);
        add(4'd6, 4'd1, 4'd0, 1'b0, FETCH, 16'd4);                    // BNE taken
        add(4'd6, 4'd1, 4'd0, 1'b0, 14'h0, 16'd4);
        add(4'd6, 4'd1, 4'd0, 1'b0, PC_WR | PC_SEL, 16'd4);
        add(4'd6, 4'd1, 4'd1, 1'b1, 14'h0, 16'd4);
        add(4'd6, 4'd1, 4'd1, 1'b0, 14'h0, 16'd4);
        add(4'd6, 4'd1, 4'd1, 1'b0, FETCH, 16'd5);                    // BNE not taken
        add(4'd6, 4'd1, 4'd1, 1'b0, 14'h0, 16'd5);
        add(4'd6, 4'd1, 4'd1, 1'b0, 14'h0, 16'd5);
        add(4'd6, 4'd1, 4'd0, 1'b0, 14'h0, 16'd5);
        add(4'd6, 4'd1, 4'd0, 1'b0, 14'h0, 16'd5);
        add(4'd5, 4'd0, 4'd0, 1'b0, FETCH, 16'd6);                    // BRR mm=0 taken
        add(4'd5, 4'd0, 4'd0, 1'b0, 14'h0, 16'd6);
        add(4'd5, 4'd0, 4'd0, 1'b0, PC_WR | PC_SEL | BR_SEL, 16'd6);
        add(4'd5, 4'd0, 4'd0, 1'b0, 14'h0, 16'd6);
        add(4'd5, 4'd0, 4'd0, 1'b0, 14'h0, 16'd6);
        add(4'd3, 4'd0, 4'd0, 1'b0, FETCH, 16'd7);                    // SWP
        add(4'd3, 4'd0, 4'd0, 1'b0, 14'h0, 16'd7);
        add(4'd3, 4'd0, 4'd0, 1'b0, 14'h0, 16'd7);
        add(4'd3, 4'd0, 4'd0, 1'b0, 14'h0, 16'd7);
        add(4'd3, 4'd0, 4'd0, 1'b0, RF_WE, 16'd7);
        add(4'd3, 4'd0, 4'd0, 1'b0, RF_WE | WA_SEL, 16'd7);
        add(4'd15, 4'd0, 4'd0, 1'b0, FETCH, 16'd8);                   // HLT
        add(4'd15, 4'd0, 4'd0, 1'b0, 14'h0, 16'd8);
        add(4'd15, 4'd0, 4'd0, 1'b0, HALTED, 16'd8);
        add(4'd15, 4'd0, 4'd0, 1'b1, HALTED, 16'd8);

        // Reset state while rst is held
        drive(4'd0, 4'd0, 4'd0, 1'b0);
        #12;
        check("reset ctl", 32'(ctl_now()), 32'(PC_RST));
        check("reset count", 32'(bus.instr_count), 32'd0);

        apply_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].mm, vecs[i].st, vecs[i].ack);
            @(negedge clk);
            check($sformatf("vec%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            check($sformatf("vec%0d count", i), 32'(bus.instr_count), 32'(vecs[i].cnt));
            step();
        end

        // STR with no ack: mem_req/dm_we must hold for exactly TIMEOUT cycles, then HALT with fault
        apply_reset();
        drive(4'd2, 4'd0, 4'd0, 1'b0);
        repeat (4) step();
        n = 0;
        for (int i = 0; i < 20 && !bus.halted; i++) begin
            if (bus.mem_req && bus.dm_we) n++;
            step();
        end
        check("timeout req cycles", 32'(n), 32'd8);
        check("timeout ctl", 32'(ctl_now()), 32'(HALTED | FAULT));
        bus.mem_ack = 1'b1;
        repeat (5) step();
        check("halt sticky ctl", 32'(ctl_now()), 32'(HALTED | FAULT));
        rst = 1'b1;
        #1;
        check("async rst clears fault", 32'(ctl_now()), 32'(PC_RST));

        // One ALU instruction, then a LOD reset asynchronously in its second MEM cycle
        apply_reset();
        drive(4'd8, 4'd0, 4'd0, 1'b0);
        repeat (6) step();
        check("pre-rst count", 32'(bus.instr_count), 32'd1);
        drive(4'd1, 4'd8, 4'd0, 1'b0);
        repeat (3) step();
        check("lod mem ctl", 32'(ctl_now()), 32'(MREQ | ALU_A | ALU_I));
        step();
        #3;
        rst = 1'b1;
        #1;
        check("mid-mem rst ctl", 32'(ctl_now()), 32'(PC_RST));
        check("mid-mem rst count", 32'(bus.instr_count), 32'd0);

        // Illegal opcode 12 goes to HALT and raises fault
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'd12, 4'd0, 4'd0, 1'b0);
        step();
        check("illegal fetch ctl", 32'(ctl_now()), 32'(FETCH));
        step();
        check("illegal decode ctl", 32'(ctl_now()), 32'h0);
        step();
        check("illegal halt ctl", 32'(ctl_now()), 32'(HALTED | FAULT));
        step();
        check("illegal halt hold", 32'(ctl_now()), 32'(HALTED | FAULT));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
